// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle control FSM for the MIPS-subset core.
// Drives datapath strobes/mux selects from the opcode/funct fields, with a
// memory ready/wait-state handshake on fetch, load and store.
// Optional macro MC_CTRL_EXC_EN adds the precise exception path: an
// illegal-opcode trap and a bus-timeout trap after TO_CYC stalled cycles.
module mc_ctrl_fsm #(
    parameter int OP_W   = 6,
    parameter int FN_W   = 6,
    parameter int TO_CYC = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [OP_W-1:0] opcode,
    input  logic [FN_W-1:0] funct,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            pcWrite,
    output logic            pcWriteCond,
    output logic            IorD,
    output logic            memRead,
    output logic            memWrite,
    output logic            IRwrite,
    output logic [1:0]      pcSource,
    output logic            aluSrcA,
    output logic [1:0]      aluSrcB,
    output logic [1:0]      aluOp,
    output logic            regWrite,
    output logic            regDst,
    output logic            memtoReg,
    output logic            linkWrite,
    output logic            ALUOutWrite,
    output logic            MDRWrite,
    output logic            excTake,
    output logic            epcWrite,
    output logic [1:0]      cause,
    output logic [3:0]      state_o
);

    typedef enum logic [3:0] {
        S_IF = 4'd0, S_ID = 4'd1, S_MEMA = 4'd2, S_MEMRD = 4'd3, S_MEMWB = 4'd4,
        S_MEMWR = 4'd5, S_EXR = 4'd6, S_WB_R = 4'd7, S_BRCH = 4'd8, S_JMP = 4'd9,
        S_JALW = 4'd10, S_EXI = 4'd11, S_WB_I = 4'd12, S_JR = 4'd13, S_EXC = 4'd14
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_LHU   = OP_W'(6'b100101);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(6'b001011);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
    localparam logic [OP_W-1:0] OP_JAL   = OP_W'(6'b000011);
    localparam logic [FN_W-1:0] FN_JR    = FN_W'(6'b001000);

    state_t state, nextState;

    // Pre-reset-gating strobes, Moore on state except the ready-qualified ones
    logic       pcWriteC, pcWriteCondC, IorDC, memReadC, memWriteC, IRwriteC;
    logic [1:0] pcSourceC, aluSrcBC, aluOpC;
    logic       aluSrcAC, regWriteC, regDstC, memtoRegC, linkWriteC;
    logic       ALUOutWriteC, MDRWriteC, excTakeC, epcWriteC;

    // zero feeds the datapath branch logic only; TO_CYC is dead without the trap path
    logic unusedOk;
    assign unusedOk = &{1'b0, zero, (TO_CYC > 1)};

`ifdef MC_CTRL_EXC_EN
    localparam int CW = $clog2(TO_CYC);
    logic          inWait, timeout;
    logic [CW-1:0] waitCnt;
    logic [1:0]    newCause, causeQ;

    assign inWait  = (state == S_IF) || (state == S_MEMRD) || (state == S_MEMWR);
    // a ready in the timeout cycle wins: the access completes, no trap
    assign timeout = inWait && !mem_ready && (waitCnt == CW'(TO_CYC - 1));

    // stall counter: counts unready cycles of one access, clears on completion or exit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                               waitCnt <= '0;
        else if (inWait && !mem_ready && !timeout)  waitCnt <= waitCnt + 1'b1;
        else                                        waitCnt <= '0;
    end

    // trap cause, loaded on the edge that enters EXC and held until the next trap
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)               causeQ <= 2'b00;
        else if (newCause != 2'b00) causeQ <= newCause;
    end
    assign cause = causeQ;
`else
    assign cause = 2'b00;
`endif

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IF;
        else          state <= nextState;
    end

    // next-state decode and per-state strobes
    always_comb begin
        nextState    = state;
        pcWriteC     = 1'b0; pcWriteCondC = 1'b0; IorDC     = 1'b0;
        memReadC     = 1'b0; memWriteC    = 1'b0; IRwriteC  = 1'b0;
        pcSourceC    = 2'b00; aluSrcAC    = 1'b0; aluSrcBC  = 2'b00;
        aluOpC       = 2'b00; regWriteC   = 1'b0; regDstC   = 1'b0;
        memtoRegC    = 1'b0; linkWriteC   = 1'b0; ALUOutWriteC = 1'b0;
        MDRWriteC    = 1'b0; excTakeC     = 1'b0; epcWriteC = 1'b0;
`ifdef MC_CTRL_EXC_EN
        newCause     = 2'b00;
`endif
        case (state)
            S_IF: begin
                memReadC = 1'b1; aluSrcBC = 2'b01;
                if (mem_ready) begin
                    IRwriteC = 1'b1; pcWriteC = 1'b1; nextState = S_ID;
                end
`ifdef MC_CTRL_EXC_EN
                else if (timeout) begin
                    nextState = S_EXC; newCause = 2'b10;
                end
`endif
            end
            S_ID: begin
                aluSrcBC = 2'b11;
                if (opcode == OP_LW || opcode == OP_SW || opcode == OP_LHU)
                    nextState = S_MEMA;
                else if (opcode == OP_RTYPE)
                    nextState = (funct == FN_JR) ? S_JR : S_EXR;
                else if (opcode == OP_ADDI || opcode == OP_SLTIU)
                    nextState = S_EXI;
                else if (opcode == OP_BEQ || opcode == OP_BNE)
                    nextState = S_BRCH;
                else if (opcode == OP_J)
                    nextState = S_JMP;
                else if (opcode == OP_JAL)
                    nextState = S_JALW;
                else begin
`ifdef MC_CTRL_EXC_EN
                    nextState = S_EXC; newCause = 2'b01;
`else
                    nextState = S_IF;
`endif
                end
            end
            S_MEMA: begin
                aluSrcAC = 1'b1; aluSrcBC = 2'b10; ALUOutWriteC = 1'b1;
                nextState = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                memReadC = 1'b1; IorDC = 1'b1;
                if (mem_ready) begin
                    MDRWriteC = 1'b1; nextState = S_MEMWB;
                end
`ifdef MC_CTRL_EXC_EN
                else if (timeout) begin
                    nextState = S_EXC; newCause = 2'b10;
                end
`endif
            end
            S_MEMWR: begin
                memWriteC = 1'b1; IorDC = 1'b1;
                if (mem_ready) nextState = S_IF;
`ifdef MC_CTRL_EXC_EN
                else if (timeout) begin
                    nextState = S_EXC; newCause = 2'b10;
                end
`endif
            end
            S_MEMWB: begin regWriteC = 1'b1; memtoRegC = 1'b1; nextState = S_IF; end
            S_EXR: begin
                aluSrcAC = 1'b1; aluOpC = 2'b10; ALUOutWriteC = 1'b1; nextState = S_WB_R;
            end
            S_WB_R: begin regWriteC = 1'b1; regDstC = 1'b1; nextState = S_IF; end
            S_EXI: begin
                aluSrcAC = 1'b1; aluSrcBC = 2'b10; ALUOutWriteC = 1'b1;
                aluOpC = (opcode == OP_SLTIU) ? 2'b11 : 2'b00;
                nextState = S_WB_I;
            end
            S_WB_I: begin regWriteC = 1'b1; nextState = S_IF; end
            S_BRCH: begin
                aluSrcAC = 1'b1; aluOpC = 2'b01; pcSourceC = 2'b01; pcWriteCondC = 1'b1;
                nextState = S_IF;
            end
            S_JMP:  begin pcWriteC = 1'b1; pcSourceC = 2'b10; nextState = S_IF; end
            S_JALW: begin
                pcWriteC = 1'b1; pcSourceC = 2'b10; regWriteC = 1'b1; linkWriteC = 1'b1;
                nextState = S_IF;
            end
            S_JR:   begin pcWriteC = 1'b1; pcSourceC = 2'b11; nextState = S_IF; end
`ifdef MC_CTRL_EXC_EN
            S_EXC:  begin pcWriteC = 1'b1; excTakeC = 1'b1; epcWriteC = 1'b1; nextState = S_IF; end
`endif
            default: nextState = S_IF;
        endcase
    end

    // reset masks every strobe combinationally so nothing leaks while held
    assign pcWrite     = reset_n & pcWriteC;
    assign pcWriteCond = reset_n & pcWriteCondC;
    assign IorD        = reset_n & IorDC;
    assign memRead     = reset_n & memReadC;
    assign memWrite    = reset_n & memWriteC;
    assign IRwrite     = reset_n & IRwriteC;
    assign pcSource    = reset_n ? pcSourceC : 2'b00;
    assign aluSrcA     = reset_n & aluSrcAC;
    assign aluSrcB     = reset_n ? aluSrcBC : 2'b00;
    assign aluOp       = reset_n ? aluOpC : 2'b00;
    assign regWrite    = reset_n & regWriteC;
    assign regDst      = reset_n & regDstC;
    assign memtoReg    = reset_n & memtoRegC;
    assign linkWrite   = reset_n & linkWriteC;
    assign ALUOutWrite = reset_n & ALUOutWriteC;
    assign MDRWrite    = reset_n & MDRWriteC;
    assign excTake     = reset_n & excTakeC;
    assign epcWrite    = reset_n & epcWriteC;
    assign state_o     = state;

endmodule
